// File: rtl/audio_fifo_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_fifo_scheduler_if
// Brief    : FIFO-side and HDMI-side signal bundle for audio_fifo_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface audio_fifo_scheduler_if #(
  parameter int LEVEL_W = 11
);
  logic               enable;
  logic [31:0]        fifo_q;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;
  logic               fifo_rd_en;
  logic               audio_clk;
  logic [15:0]        sample_left;
  logic [15:0]        sample_right;
  logic               playing;
  logic [15:0]        underrun_count;
  logic               underrun_flag;

  modport master (
    output enable, fifo_q, fifo_empty, fifo_level,
    input  fifo_rd_en, audio_clk, sample_left, sample_right,
    input  playing, underrun_count, underrun_flag
  );

  modport slave (
    input  enable, fifo_q, fifo_empty, fifo_level,
    output fifo_rd_en, audio_clk, sample_left, sample_right,
    output playing, underrun_count, underrun_flag
  );
endinterface
`default_nettype wire

// File: rtl/audio_fifo_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : audio_fifo_scheduler
// Brief    : Fractional-rate audio sample scheduler draining the audio FIFO.
//            Optional macro AUDIO_SCHED_MUTE_EN mutes output on long underrun.
// Revision : 1.0 - initial release
// ============================================================================
module audio_fifo_scheduler #(
  parameter int CLK_HZ     = 74250000,
  parameter int SAMPLE_HZ  = 48000,
  parameter int ACC_W      = 28,
  parameter int LEVEL_W    = 11,
  parameter int PREFILL    = 256,
  parameter int MUTE_AFTER = 64
) (
  input  wire logic              clk_pixel,
  input  wire logic              reset_n,
  audio_fifo_scheduler_if.slave  bus
);

  localparam logic [ACC_W:0] c_CLK_HZ    = (ACC_W+1)'(CLK_HZ);
  localparam logic [ACC_W:0] c_SAMPLE_HZ = (ACC_W+1)'(SAMPLE_HZ);
  localparam logic [ACC_W:0] c_HALF_HZ   = (ACC_W+1)'(CLK_HZ / 2);
  // Run-length counter must reach whichever threshold is larger.
  localparam int c_CONSEC_MAX = (PREFILL > MUTE_AFTER) ? PREFILL : MUTE_AFTER;
  localparam int c_CONSEC_W   = $clog2(c_CONSEC_MAX + 1);
  localparam logic [c_CONSEC_W-1:0] c_REARM = c_CONSEC_W'(PREFILL);
`ifdef AUDIO_SCHED_MUTE_EN
  localparam logic [c_CONSEC_W-1:0] c_MUTE  = c_CONSEC_W'(MUTE_AFTER);
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PREFILL = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ACC_W-1:0]      r_acc;
  logic [ACC_W:0]        w_acc_sum;
  logic [ACC_W-1:0]      w_acc_nxt;
  logic                  w_tick;
  logic                  r_audio_clk;
  logic                  r_rd_en;
  logic                  r_cap;
  logic [15:0]           r_left;
  logic [15:0]           r_right;
  logic [15:0]           r_ur_count;
  logic                  r_ur_flag;
  logic [c_CONSEC_W-1:0] r_consec;
  logic [c_CONSEC_W-1:0] w_consec_inc;
  logic                  w_level_ok;
  logic                  w_pop_req;
  logic                  w_underrun;
  logic                  w_rearm;

  // Fractional accumulator: one tick per CLK_HZ/SAMPLE_HZ cycles on average.
  always_comb begin
    w_acc_sum = {1'b0, r_acc} + c_SAMPLE_HZ;
    w_tick    = (w_acc_sum >= c_CLK_HZ);
    w_acc_nxt = w_tick ? ACC_W'(w_acc_sum - c_CLK_HZ) : ACC_W'(w_acc_sum);
  end

  always_comb begin
    w_level_ok   = (32'(bus.fifo_level) >= 32'(PREFILL));
    w_consec_inc = r_consec + 1'b1;
    w_pop_req    = w_tick && bus.enable && !bus.fifo_empty &&
                   ((r_state == S_RUN) || ((r_state == S_PREFILL) && w_level_ok));
    w_underrun   = w_tick && bus.enable && bus.fifo_empty && (r_state == S_RUN);
    w_rearm      = w_underrun && (w_consec_inc >= c_REARM);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_PREFILL;
        S_PREFILL: if (w_pop_req) w_state_nxt = S_RUN;
        S_RUN:     if (w_rearm)   w_state_nxt = S_PREFILL;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_acc       <= '0;
      r_audio_clk <= 1'b0;
    end else begin
      r_acc       <= w_acc_nxt;
      r_audio_clk <= ({1'b0, r_acc} >= c_HALF_HZ);
    end
  end

  // Pop on tick+1; FIFO data is valid and captured on tick+2.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_en <= 1'b0;
      r_cap   <= 1'b0;
    end else begin
      r_rd_en <= w_pop_req;
      r_cap   <= r_rd_en;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_left  <= '0;
      r_right <= '0;
    end else if (!bus.enable || (r_state == S_IDLE)) begin
      r_left  <= '0;
      r_right <= '0;
    end else if (r_cap) begin
      r_left  <= bus.fifo_q[15:0];
      r_right <= bus.fifo_q[31:16];
`ifdef AUDIO_SCHED_MUTE_EN
    end else if (w_underrun && (w_consec_inc >= c_MUTE)) begin
      r_left  <= '0;
      r_right <= '0;
`endif
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_ur_count <= '0;
      r_ur_flag  <= 1'b0;
    end else begin
      if (w_underrun && (r_ur_count != 16'hFFFF)) begin
        r_ur_count <= r_ur_count + 16'd1;
      end
      if (!bus.enable) begin
        r_ur_flag <= 1'b0;
      end else if (w_underrun) begin
        r_ur_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_consec <= '0;
    end else if (!bus.enable || (r_state != S_RUN) || w_pop_req || w_rearm) begin
      r_consec <= '0;
    end else if (w_underrun) begin
      r_consec <= w_consec_inc;
    end
  end

  assign bus.fifo_rd_en     = r_rd_en;
  assign bus.audio_clk      = r_audio_clk;
  assign bus.sample_left    = r_left;
  assign bus.sample_right   = r_right;
  assign bus.playing        = (r_state == S_RUN);
  assign bus.underrun_count = r_ur_count;
  assign bus.underrun_flag  = r_ur_flag;

endmodule
`default_nettype wire

// File: tb/tb_audio_fifo_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_fifo_scheduler
// Brief    : Directed bench for audio_fifo_scheduler with a FIFO model and
//            a capture scoreboard. Scaled clock: 1000 Hz pixel, 48 Hz audio.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_fifo_scheduler;
  localparam int CLK_HZ     = 1000;
  localparam int SAMPLE_HZ  = 48;
  localparam int ACC_W      = 28;
  localparam int LEVEL_W    = 11;
  localparam int PREFILL    = 256;
  localparam int MUTE_AFTER = 3;

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  audio_fifo_scheduler_if #(.LEVEL_W(LEVEL_W)) bus ();

  audio_fifo_scheduler #(
    .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .ACC_W(ACC_W),
    .LEVEL_W(LEVEL_W), .PREFILL(PREFILL), .MUTE_AFTER(MUTE_AFTER)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference tick model
  logic [ACC_W-1:0] m_acc;
  logic             m_tick, m_tick_d, m_empty_d;
  always_comb m_tick = ((32'(m_acc) + SAMPLE_HZ) >= CLK_HZ);
  always @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      m_acc     <= '0;
      m_tick_d  <= 1'b0;
      m_empty_d <= 1'b0;
    end else begin
      m_acc     <= m_tick ? ACC_W'(32'(m_acc) + SAMPLE_HZ - CLK_HZ)
                          : ACC_W'(32'(m_acc) + SAMPLE_HZ);
      m_tick_d  <= m_tick;
      m_empty_d <= bus.fifo_empty;
    end
  end

  // FIFO model, pop monitor and scoreboard push
  logic [31:0] next_word = 32'h1234ABCD;
  logic [31:0] sb_q[$];
  bit          sb_on = 1'b0;
  bit          gap_track = 1'b0;
  int          pop_cnt = 0, bad_pop = 0, misalign = 0;
  int          cyc = 0, last_pop = 0, gap_min = 0, gap_max = 0;
  logic        pend1 = 1'b0, pend2 = 1'b0;

  always @(posedge clk_pixel) begin
    cyc   <= cyc + 1;
    pend1 <= bus.fifo_rd_en;
    pend2 <= pend1;
    if (bus.fifo_rd_en === 1'b1) begin
      bus.fifo_q <= next_word;
      if (sb_on) sb_q.push_back(next_word);
      next_word <= next_word + 32'h01010101;
      pop_cnt   <= pop_cnt + 1;
      last_pop  <= cyc;
      if (!m_tick_d) misalign <= misalign + 1;
      if (m_empty_d) bad_pop  <= bad_pop + 1;
      if (gap_track) begin
        if (cyc - last_pop < gap_min) gap_min <= cyc - last_pop;
        if (cyc - last_pop > gap_max) gap_max <= cyc - last_pop;
      end
    end
  end

  // Scoreboard pop: DUT samples updated two edges after the pop edge
  always @(negedge clk_pixel) begin
    logic [31:0] exp_w;
    if (pend2 && sb_on) begin
      chk("sb_depth", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_w = sb_q.pop_front();
        chk("sb_right", 32'(bus.sample_right), 32'(exp_w[31:16]));
        chk("sb_left",  32'(bus.sample_left),  32'(exp_w[15:0]));
      end
    end
  end

  task automatic wait_tick(input string tag);
    int k = 0;
    @(negedge clk_pixel);
    while (!m_tick && k < 100) begin
      @(negedge clk_pixel);
      k++;
    end
    chk(tag, 32'(m_tick), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_en"},  32'(bus.fifo_rd_en), 32'd0);
    chk({tag, "_aclk"},   32'(bus.audio_clk), 32'd0);
    chk({tag, "_left"},   32'(bus.sample_left), 32'd0);
    chk({tag, "_right"},  32'(bus.sample_right), 32'd0);
    chk({tag, "_play"},   32'(bus.playing), 32'd0);
    chk({tag, "_urcnt"},  32'(bus.underrun_count), 32'd0);
    chk({tag, "_urflag"}, 32'(bus.underrun_flag), 32'd0);
  endtask

  initial begin
    logic [31:0] last_smp;
    logic        prev_aclk;
    int          p0;
    int          k;

    bus.enable     = 1'b0;
    bus.fifo_empty = 1'b0;
    bus.fifo_level = '0;
    repeat (3) @(negedge clk_pixel);
    chk_reset_vals("reset");

    // Prefill: level ramps to 255, no playback
    reset_n    = 1'b1;
    bus.enable = 1'b1;
    sb_on      = 1'b1;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk_pixel);
      bus.fifo_level = LEVEL_W'(i + 1);
    end
    repeat (60) @(negedge clk_pixel);
    chk("prefill_pops", 32'(pop_cnt), 32'd0);
    chk("prefill_playing", 32'(bus.playing), 32'd0);

    wait_tick("align_prefill");
    @(negedge clk_pixel);
    bus.fifo_level = LEVEL_W'(PREFILL);
    wait_tick("first_tick");
    chk("play_before_first_tick", 32'(bus.playing), 32'd0);
    @(negedge clk_pixel);
    chk("first_pop", 32'(bus.fifo_rd_en), 32'd1);
    chk("playing_rise", 32'(bus.playing), 32'd1);
    repeat (2) @(negedge clk_pixel);
    chk("data_right", 32'(bus.sample_right), 32'h1234);
    chk("data_left",  32'(bus.sample_left),  32'hABCD);

    // Samples must be stable through the next audio_clk rising edge
    k = 0;
    prev_aclk = bus.audio_clk;
    @(negedge clk_pixel);
    while (!(bus.audio_clk && !prev_aclk) && k < 50) begin
      prev_aclk = bus.audio_clk;
      @(negedge clk_pixel);
      k++;
    end
    chk("aclk_rise", 32'(bus.audio_clk), 32'd1);
    chk("stable_right", 32'(bus.sample_right), 32'h1234);
    chk("stable_left",  32'(bus.sample_left),  32'hABCD);

    // Rate: exactly SAMPLE_HZ pops in any CLK_HZ-cycle window
    gap_min   = 1000000;
    gap_max   = 0;
    gap_track = 1'b1;
    p0        = pop_cnt;
    repeat (CLK_HZ) @(negedge clk_pixel);
    gap_track = 1'b0;
    chk("rate_pops", 32'(pop_cnt - p0), 32'(SAMPLE_HZ));
    chk("gap_min", 32'(gap_min), 32'd20);
    chk("gap_max", 32'(gap_max), 32'd21);

    // Underrun for 5 ticks
    wait_tick("align_ur");
    repeat (4) @(negedge clk_pixel);
    last_smp = {bus.sample_right, bus.sample_left};
    bus.fifo_empty = 1'b1;
    p0 = pop_cnt;
    repeat (2) wait_tick("ur_tick");
    repeat (2) @(negedge clk_pixel);
    chk("ur_held2", {bus.sample_right, bus.sample_left}, last_smp);
    repeat (3) wait_tick("ur_tick");
    repeat (2) @(negedge clk_pixel);
    chk("ur_pops", 32'(pop_cnt - p0), 32'd0);
    chk("ur_count", 32'(bus.underrun_count), 32'd5);
    chk("ur_flag", 32'(bus.underrun_flag), 32'd1);
    chk("ur_playing", 32'(bus.playing), 32'd1);
`ifdef AUDIO_SCHED_MUTE_EN
    chk("ur_muted", {bus.sample_right, bus.sample_left}, 32'd0);
`else
    chk("ur_held5", {bus.sample_right, bus.sample_left}, last_smp);
`endif

    bus.fifo_empty = 1'b0;
    wait_tick("resume_tick");
    @(negedge clk_pixel);
    chk("resume_pop", 32'(bus.fifo_rd_en), 32'd1);
    repeat (3) @(negedge clk_pixel);

    // Re-arm: PREFILL consecutive empty ticks drop back to PREFILL
    bus.fifo_empty = 1'b1;
    bus.fifo_level = '0;
    repeat (PREFILL - 1) wait_tick("rearm_tick");
    @(negedge clk_pixel);
    chk("rearm_still_playing", 32'(bus.playing), 32'd1);
    wait_tick("rearm_last");
    @(negedge clk_pixel);
    chk("rearm_playing", 32'(bus.playing), 32'd0);
    chk("rearm_count", 32'(bus.underrun_count), 32'd261);
    bus.fifo_empty = 1'b0;
    bus.fifo_level = LEVEL_W'(PREFILL);
    wait_tick("rearm_level_tick");
    @(negedge clk_pixel);
    chk("rearm_pop", 32'(bus.fifo_rd_en), 32'd1);
    chk("rearm_play", 32'(bus.playing), 32'd1);
    repeat (3) @(negedge clk_pixel);

    // Enable drop while a pop is in flight
    wait_tick("en_tick");
    @(negedge clk_pixel);
    chk("en_pop", 32'(bus.fifo_rd_en), 32'd1);
    sb_on      = 1'b0;
    bus.enable = 1'b0;
    @(negedge clk_pixel);
    chk("en_playing", 32'(bus.playing), 32'd0);
    chk("en_left", 32'(bus.sample_left), 32'd0);
    chk("en_right", 32'(bus.sample_right), 32'd0);
    chk("en_flag", 32'(bus.underrun_flag), 32'd0);
    chk("en_count", 32'(bus.underrun_count), 32'd261);
    repeat (3) @(negedge clk_pixel);
    chk("en_discard", {bus.sample_right, bus.sample_left}, 32'd0);

    // Asynchronous reset on the pop cycle
    bus.enable = 1'b1;
    wait_tick("rst_tick");
    @(negedge clk_pixel);
    chk("rst_pop", 32'(bus.fifo_rd_en), 32'd1);
    p0 = pop_cnt;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    repeat (3) @(negedge clk_pixel);
    chk("rst_no_capture", {bus.sample_right, bus.sample_left}, 32'd0);
    chk("rst_no_pop", 32'(pop_cnt - p0), 32'd0);

    chk("misaligned_pops", 32'(misalign), 32'd0);
    chk("pops_while_empty", 32'(bad_pop), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
